// File: rtl/seg7_pattern_decoder.sv
// Decodes a stable active-low 7-segment pattern back to its hex digit and
// hands it out on valid/ready. Build option SEG_ERR_COUNT_EN adds an invalid-pattern counter.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [6:0] HEX_IN,
  output logic [3:0] out_data,
  output logic       out_blank,
  output logic       out_invalid,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] err_count
);

  typedef enum logic [0:0] {
    WAIT_STABLE = 1'b0,
    PRESENT     = 1'b1
  } state_t;

  // Result packing is {invalid, blank, data}.
  function automatic logic [5:0] decode_pattern(input logic [6:0] pat);
    case (pat)
      7'h40:   decode_pattern = {2'b00, 4'h0};
      7'h79:   decode_pattern = {2'b00, 4'h1};
      7'h24:   decode_pattern = {2'b00, 4'h2};
      7'h30:   decode_pattern = {2'b00, 4'h3};
      7'h19:   decode_pattern = {2'b00, 4'h4};
      7'h12:   decode_pattern = {2'b00, 4'h5};
      7'h02:   decode_pattern = {2'b00, 4'h6};
      7'h78:   decode_pattern = {2'b00, 4'h7};
      7'h00:   decode_pattern = {2'b00, 4'h8};
      7'h10:   decode_pattern = {2'b00, 4'h9};
      7'h08:   decode_pattern = {2'b00, 4'hA};
      7'h03:   decode_pattern = {2'b00, 4'hB};
      7'h46:   decode_pattern = {2'b00, 4'hC};
      7'h21:   decode_pattern = {2'b00, 4'hD};
      7'h06:   decode_pattern = {2'b00, 4'hE};
      7'h0E:   decode_pattern = {2'b00, 4'hF};
      7'h7F:   decode_pattern = {2'b01, 4'h0};
      default: decode_pattern = {2'b10, 4'h0};
    endcase
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [6:0]       r_hex_q;
  logic [6:0]       r_last_pat;
  logic             r_have_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gap;
  logic [3:0]       r_data;
  logic             r_blank;
  logic             r_invalid;
  logic             r_valid;

  logic             w_same;
  logic             w_stable;
  logic             w_new;
  logic             w_load;
  logic             w_done;
  logic [5:0]       w_dec;

  assign w_same   = (HEX_IN == r_hex_q);
  // Counter saturates, so ">=" lets a pattern that settled during PRESENT still be accepted later.
  assign w_stable = w_same && (r_cnt >= CNT_W'(STABLE_CYCLES - 1));
  assign w_new    = w_stable && !r_gap &&
                    (!r_have_last || (r_hex_q != r_last_pat));
  assign w_dec    = decode_pattern(r_hex_q);

  assign out_data    = r_data;
  assign out_blank   = r_blank;
  assign out_invalid = r_invalid;
  assign out_valid   = r_valid;

  // Next-state and handshake decisions.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      WAIT_STABLE: begin
        if (w_new) begin
          w_next_state = PRESENT;
          w_load       = 1'b1;
        end else begin
          w_next_state = WAIT_STABLE;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          w_next_state = WAIT_STABLE;
          w_done       = 1'b1;
        end else begin
          w_next_state = PRESENT;
        end
      end
      default: begin
        w_next_state = WAIT_STABLE;
      end
    endcase
  end

  // Sampling, stability tracking, state and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= WAIT_STABLE;
      r_hex_q     <= 7'h7F;
      r_last_pat  <= 7'h7F;
      r_have_last <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_gap       <= 1'b0;
      r_data      <= 4'h0;
      r_blank     <= 1'b0;
      r_invalid   <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_hex_q <= HEX_IN;
      r_state <= w_next_state;
      // Blocks acceptance on the edge right after a handshake.
      r_gap   <= w_done;
      if (!w_same) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (r_cnt != CNT_W'(STABLE_CYCLES)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_load) begin
        r_data      <= w_dec[3:0];
        r_blank     <= w_dec[4];
        r_invalid   <= w_dec[5];
        r_valid     <= 1'b1;
        r_last_pat  <= r_hex_q;
        r_have_last <= 1'b1;
      end else if (w_done) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SEG_ERR_COUNT_EN
  logic [7:0] r_err_count;

  // Counts accepted invalid patterns, saturating.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_err_count <= 8'h00;
    end else if (w_load && w_dec[5] && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'h01;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: doc/seg7_pattern_decoder.md
Name: seg7_pattern_decoder

Overview:
- Inverse of the board's hex-to-seven-segment driver. Samples one active-low 7-segment pattern bus and checks that it is stable. Decodes it back to a 4-bit hex value and delivers it over a valid/ready handshake.
- Used for display loopback checking and for reading digit patterns produced by other lab blocks. Sits between a HEX-style pattern source and a consumer such as a checker or LED status logic.

Parameters:
- STABLE_CYCLES, 4, number of additional consecutive identical samples required before a pattern is accepted (1..255).
- CNT_W, 8, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- HEX_IN  in  7  active-low segment pattern; bit0 = segment a … bit6 = segment g; 0 = segment lit.
- out_data  out  4  decoded hex value.
- out_blank  out  1  accepted pattern was 7'h7F (all segments off).
- out_invalid  out  1  accepted pattern matches no table entry.
- out_valid  out  1  transaction available.
- out_ready  in  1  consumer accepts the transaction.
- err_count  out  8  invalid-pattern count (see Optional Feature).

Behaviour:
- Reset state:
  - out_data=0, out_blank=0, out_invalid=0, out_valid=0, err_count=0.
  - Stability counter=0. Sample register hex_q=7'h7F. have_last=0. FSM=WAIT_STABLE.
- Input register: hex_q <= HEX_IN on every edge.
- Stability counter:
  - Cleared to 0 when HEX_IN != hex_q.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Decode table, active-low, hex value : pattern:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - blank: 7F gives out_blank=1, out_data=0.
  - Any other pattern gives out_invalid=1, out_data=0.
- FSM states: WAIT_STABLE, PRESENT.
- WAIT_STABLE:
  - Accept when HEX_IN == hex_q and counter == STABLE_CYCLES-1. That is, the pattern has been sampled identically at STABLE_CYCLES+1 consecutive edges.
  - On accept, if have_last=0 or the pattern != last_pat:
    - Load decode results into the output registers.
    - Set last_pat=pattern and have_last=1.
    - Set out_valid=1 and go to PRESENT.
  - On accept with pattern == last_pat: no transaction (duplicate suppression); stay in WAIT_STABLE.
- PRESENT:
  - out_valid=1. out_data, out_blank and out_invalid are held constant.
  - Stability tracking continues; HEX_IN changes do not alter the outputs.
  - When out_ready=1 at an edge: out_valid=0 on that edge and return to WAIT_STABLE.
- Spacing: out_valid is low for at least one cycle between transactions. A pattern that became stable during PRESENT is emitted at the earliest on the second edge after the handshake.
- Latency: a new pattern first sampled at edge N raises out_valid at edge N+STABLE_CYCLES (registered output, no combinational path HEX_IN→outputs).
- Glitch: any single-cycle deviation restarts the count from 0.
- Reset mid-transaction: the pending transaction is discarded and all state returns to reset values on that edge. The next stable pattern is always emitted (have_last=0).
- out_ready while out_valid=0: ignored.

Optional Feature:
- Macro: SEG_ERR_COUNT_EN.
- Defined: err_count increments by 1, saturating at 8'hFF, on every accept in WAIT_STABLE that loads out_invalid=1. Suppressed duplicates do not count. Cleared by reset.
- Not defined: err_count is a constant 8'h00 and no counter flops are generated.

Test Plan:
- Reset, then HEX_IN=7'h24 held, out_ready=1 → out_valid pulses 1 cycle at the 4th edge after first sample; out_data=2, out_blank=0, out_invalid=0.
- Sweep all 16 table patterns, each held 10 cycles, out_ready=1 → 16 transactions with out_data 0..F in order; then 7'h7F → out_blank=1, out_data=0.
- HEX_IN=7'h30 with a 1-cycle glitch to 7'h31 every 3 cycles for 30 cycles → no out_valid; glitch removed → out_data=3 after STABLE_CYCLES edges.
- HEX_IN=7'h12, out_ready=0 for 20 cycles while HEX_IN changes to 7'h02 → out_valid held, out_data=5 unchanged. Raise out_ready → 5 accepted; out_data=6 presented no earlier than 2 edges later. Same 7'h02 held 50 more cycles → no further transaction.
- SEG_ERR_COUNT_EN defined: patterns 7'h55, 7'h2A, 7'h55 in turn, each stable → three transactions with out_invalid=1; err_count=3. Without the macro, err_count stays 0.
- Assert reset for 1 cycle while out_valid=1 (HEX_IN=7'h79) → out_valid=0 next edge. The same 7'h79 is re-emitted with out_data=1 after STABLE_CYCLES edges.
